// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared types and op-decode helpers for the iterative RV-M unit.
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  // RV funct3 encoding of the M-extension ops
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

  function automatic logic is_signed_a(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_high(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_fixup.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_fixup
// Purpose  : Maps raw magnitude results (product, or remainder:quotient) to
//            the final signed/selected result for the op in flight.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_fixup
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  muldiv_op_e             op_i,
  input  logic                   neg_i,
  input  logic [2*WIDTH-1:0]     raw_i,
  output logic [WIDTH-1:0]       result_o
);

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_div_sel;
  logic [WIDTH-1:0]   w_div_res;

  // Product magnitude never exceeds 2^(2W-1), so a 2W-bit negate is exact.
  assign w_prod    = neg_i ? -raw_i : raw_i;
  // Divider layout: upper half holds the remainder, lower half the quotient.
  assign w_div_sel = is_rem(op_i) ? raw_i[2*WIDTH-1:WIDTH] : raw_i[WIDTH-1:0];
  assign w_div_res = neg_i ? -w_div_sel : w_div_sel;

  // Select the half or the divider result that the op asks for
  always_comb begin
    result_o = w_prod[WIDTH-1:0];
    if (is_div(op_i)) begin
      result_o = w_div_res;
    end else if (is_high(op_i)) begin
      result_o = w_prod[2*WIDTH-1:WIDTH];
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_iter
// Purpose  : Iterative radix-2 RV-M multiply/divide unit with valid/ready
//            handshakes and flush. One result bit per cycle on magnitudes,
//            sign fix-up applied on the final iteration.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  muldiv_state_e       state_q, state_d;
  muldiv_op_e          op_q, op_d;
  logic                neg_q, neg_d;
  logic [WIDTH-1:0]    opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0]  acc_q, acc_d;       // {hi, lo}: product or {rem, quot}
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]    result_q, result_d;

  muldiv_op_e          w_op;
  logic                w_a_neg, w_b_neg;
  logic [WIDTH-1:0]    w_a_mag, w_b_mag;
  logic                w_special;
  logic [WIDTH-1:0]    w_special_res;
  logic [WIDTH:0]      w_mul_sum;
  logic [2*WIDTH-1:0]  w_mul_next;
  logic [WIDTH:0]      w_div_shift;
  logic [WIDTH:0]      w_div_diff;
  logic                w_div_ge;
  logic [2*WIDTH-1:0]  w_div_next;
  logic [2*WIDTH-1:0]  w_step;
  logic [WIDTH-1:0]    w_fix_result;

  // Request decode: magnitudes and the bypass cases for the divider
  assign w_op      = muldiv_op_e'(in_op);
  assign w_a_neg   = is_signed_a(w_op) & in_a[WIDTH-1];
  assign w_b_neg   = is_signed_b(w_op) & in_b[WIDTH-1];
  assign w_a_mag   = w_a_neg ? -in_a : in_a;
  assign w_b_mag   = w_b_neg ? -in_b : in_b;
  assign w_special = is_div(w_op) &&
                     ((in_b == '0) ||
                      (is_signed_a(w_op) && (in_a == MIN_NEG) && (in_b == '1)));
  assign w_special_res = (in_b == '0) ? (is_rem(w_op) ? in_a : '1)
                                      : (is_rem(w_op) ? '0   : in_a);

  // Shift-add step: add multiplicand into the high half on LSB, shift right
  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                      (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

  // Restoring divide step: shift next dividend bit into the remainder
  assign w_div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_div_diff  = w_div_shift - {1'b0, opnd_q};
  assign w_div_ge    = ~w_div_diff[WIDTH];
  assign w_div_next  = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                        acc_q[WIDTH-2:0], w_div_ge};

  assign w_step = is_div(op_q) ? w_div_next : w_mul_next;

  // Final-iteration result is fixed up straight from the step output
  muldiv_fixup #(.WIDTH(WIDTH)) u_fixup (
    .op_i     (op_q),
    .neg_i    (neg_q),
    .raw_i    (w_step),
    .result_o (w_fix_result)
  );

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_result = result_q;

  // Next-state logic for the FSM, counter and datapath registers
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid && !flush) begin
          op_d = w_op;
          if (is_div(w_op)) begin
            opnd_d = w_b_mag;
            acc_d  = {{WIDTH{1'b0}}, w_a_mag};
            neg_d  = is_rem(w_op) ? w_a_neg : (w_a_neg ^ w_b_neg);
          end else begin
            opnd_d = w_a_mag;
            acc_d  = {{WIDTH{1'b0}}, w_b_mag};
            neg_d  = w_a_neg ^ w_b_neg;
          end
          if (w_special) begin
            result_d = w_special_res;
            state_d  = DONE;
          end else begin
            cnt_d   = CNT_W'(WIDTH - 1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = w_step;
          if (cnt_q == '0) begin
            result_d = w_fix_result;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      DONE: begin
        if (flush || out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_iter
// Purpose  : Directed and randomized self-checking bench for muldiv_iter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;
  import muldiv_pkg::*;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;

  int n_vec = 0;
  int n_bad = 0;

  muldiv_iter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent 64-bit reference of the RV-M semantics
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] sa, sb, za, zb, p;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    za = {32'd0, a};
    zb = {32'd0, b};
    ia = a;
    ib = b;
    case (op)
      3'b000: begin p = za * zb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * zb; return p[63:32]; end
      3'b011: begin p = za * zb; return p[63:32]; end
      3'b100: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || ((op == 3'b100 || op == 3'b110) &&
                              a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return WIDTH + 1;
  endfunction

  // Issue one op, scramble inputs while busy, check latency and result,
  // then let the out_ready handshake complete.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input string tag);
    int cnt;
    cnt = 0;
    while (!in_ready && cnt < 100) begin
      @(posedge clk); #1; cnt++;
    end
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_op = 3'($urandom);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      @(posedge clk); #1; cnt++;
    end
    check_eq({tag, "_lat"}, 64'(cnt + 1), 64'(exp_lat));
    check_eq(tag, 64'(out_result), 64'(exp));
    @(posedge clk); #1;
  endtask

  logic [31:0] corner [5];
  logic [31:0] ra, rb;
  logic [2:0]  rop;
  logic        seen;

  initial begin
    corner[0] = 32'h0000_0000; corner[1] = 32'h0000_0001; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF;
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0;
    flush = 1'b0; out_ready = 1'b1;
    #12;
    check_eq("rst_in_ready",  64'(in_ready),   64'd1);
    check_eq("rst_out_valid", 64'(out_valid),  64'd0);
    check_eq("rst_result",    64'(out_result), 64'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Multiply family
    run_op(OP_MULH,   32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33, "mulh");
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 33, "mulhu");
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 33, "mulhsu");
    run_op(OP_MUL,    32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 33, "mul");
    run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max");
    run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min");
    run_op(OP_MUL,    32'h0, 32'h5, 32'h0, 33, "mul_zero");

    // Divide family
    run_op(OP_DIV,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFD, 33, "div_neg");
    run_op(OP_REM,  32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 33, "rem_neg");
    run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, "divu");
    run_op(OP_REMU, 32'd100, 32'd7, 32'd2,  33, "remu");
    run_op(OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, "div_negb");
    run_op(OP_REM,  32'd7, 32'hFFFF_FFFE, 32'h1, 33, "rem_negb");
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 33, "divu_max");

    // Bypass cases
    run_op(OP_DIVU, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1, "divu_by0");
    run_op(OP_DIV,  32'h1234, 32'h0, 32'hFFFF_FFFF, 1, "div_by0");
    run_op(OP_REMU, 32'h1234, 32'h0, 32'h1234, 1, "remu_by0");
    run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, "rem_ovf");
    run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");

    // Back-pressure: result held, no new accept, release next cycle
    out_ready = 1'b0;
    in_op = OP_DIVU; in_a = 32'd100; in_b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 0; k < 60 && !out_valid; k++) begin
      @(posedge clk); #1;
    end
    for (int k = 0; k < 5; k++) begin
      check_eq("bp_valid",  64'(out_valid),  64'd1);
      check_eq("bp_result", 64'(out_result), 64'd14);
      check_eq("bp_ready",  64'(in_ready),   64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_release_ready", 64'(in_ready),  64'd1);
    check_eq("bp_release_valid", 64'(out_valid), 64'd0);

    // Flush in BUSY
    in_op = OP_DIV; in_a = 32'hFFFF_FFF9; in_b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 9; k++) begin
      seen = seen | out_valid;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_busy_valid", 64'(seen | out_valid), 64'd0);
    check_eq("flush_busy_ready", 64'(in_ready), 64'd1);
    run_op(OP_MUL, 32'd3, 32'd5, 32'd15, 33, "mul_after_flush");

    // Flush wins over a request in IDLE
    in_op = OP_MUL; in_a = 32'd2; in_b = 32'd2; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check_eq("flush_idle_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      seen = seen | out_valid;
      @(posedge clk); #1;
    end
    check_eq("flush_idle_valid", 64'(seen), 64'd0);

    // Asynchronous reset in the middle of BUSY
    in_op = OP_MUL; in_a = 32'd7; in_b = 32'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #4 rst = 1'b1;
    #1;
    check_eq("arst_in_ready",  64'(in_ready),   64'd1);
    check_eq("arst_out_valid", 64'(out_valid),  64'd0);
    check_eq("arst_result",    64'(out_result), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Randomized ops against the reference model
    for (int i = 0; i < 2000; i++) begin
      rop = 3'($urandom);
      ra  = ($urandom_range(0, 1) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
      rb  = ($urandom_range(0, 1) == 0) ? corner[$urandom_range(0, 4)] : 32'($urandom);
      run_op(rop, ra, rb, ref_model(rop, ra, rb), ref_lat(rop, ra, rb),
             $sformatf("rnd%0d_op%0d_%h_%h", i, rop, ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/muldiv_iter.md
Name: muldiv_iter

Overview:
- Parametrised, multi-cycle RV-M execution unit: MUL/MULH/MULHSU/MULHU plus DIV/DIVU/REM/REMU.
- Successor to the single-cycle combinational multiplier path in the ALU. Removes the 64-bit array multiply from the critical path and adds division.
- Iterative radix-2 engine, one result bit per cycle. Valid/ready handshake on both sides so the pipeline stalls EX while the unit is busy.
- Pipeline flush kills an in-flight operation.

Parameters:
- WIDTH, 32, operand/result width in bits; must be even and >= 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept; high only in IDLE.
- in_op  in  3  muldiv_op_e (RV funct3 encoding).
- in_a  in  WIDTH  rs1 operand.
- in_b  in  WIDTH  rs2 operand.
- flush  in  1  synchronous kill of the current operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- out_result  out  WIDTH  result.

Behaviour:
- Reset (async, any state): state=IDLE, in_ready=1, out_valid=0, out_result=0, counter=0, internal accumulators=0.
- States:
  - IDLE: accept when in_valid&in_ready. Latch op and operands. Go to BUSY, or go to DONE for a special case.
  - BUSY: counter runs WIDTH-1 down to 0, one shift-add (mul) or shift-subtract restoring step (div) per cycle. At counter==0, apply sign fix-up and register out_result, then go to DONE.
  - DONE: out_valid=1, out_result held stable until out_valid&out_ready, then IDLE. in_ready=0 in DONE, so there is no back-to-back overlap.
- Latency (accepting edge = cycle 0):
  - Normal ops: out_valid is high from cycle WIDTH+1.
  - Special cases: out_valid is high from cycle 1.
- Op encoding:
  - 000 MUL: low WIDTH bits of the product.
  - 001 MULH: high half, signed x signed.
  - 010 MULHSU: high half, signed a x unsigned b.
  - 011 MULHU: high half, unsigned x unsigned.
  - 100 DIV: signed quotient, truncated toward zero.
  - 101 DIVU: unsigned quotient.
  - 110 REM: signed remainder; sign of the dividend.
  - 111 REMU: unsigned remainder.
- Signed handling: iterate on magnitudes (2*WIDTH product register, WIDTH quotient/remainder). Negate at fix-up per sign rules. Results must be bit-exact to the 2*WIDTH-bit mathematical definition.
- Special cases (bypass BUSY):
  - b==0: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a = most-negative, b = -1): DIV gives a; REM gives 0.
  - MUL with a==0 or b==0 is NOT special-cased; it takes the normal latency.
- Flush:
  - From BUSY or DONE: go to IDLE at the next edge. out_valid=0 after that edge; no result is delivered.
  - Flush in IDLE together with in_valid: the request is not accepted (flush wins). The next state stays IDLE.
- out_ready asserted outside DONE has no effect.
- in_a/in_b/in_op changes while BUSY have no effect, because operands were latched at accept.

Decomposition:
- Package muldiv_pkg holds:
  - typedef enum logic[2:0] muldiv_op_e (8 ops above).
  - typedef enum logic[1:0] muldiv_state_e {IDLE, BUSY, DONE}.
  - Helper functions is_div(op), is_signed_a(op), is_signed_b(op), is_high(op).
- One sub-module, muldiv_fixup: combinational sign/selection stage mapping raw magnitude results plus op/sign bits to the final result. The top module owns the FSM, counter and datapath registers.

Test Plan (WIDTH=32, out_ready=1 unless stated):
- MULH a=0xFFFFFFFF, b=0x00000002 -> out_result=0xFFFFFFFF, out_valid first high 33 cycles after accept. Same operands with MULHU -> 0x00000001; MULHSU -> 0xFFFFFFFF; MUL -> 0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFF (-1); DIVU a=100, b=7 -> 14; REMU -> 2.
- DIVU a=0x1234, b=0 -> 0xFFFFFFFF at cycle 1; REM a=0x80000000, b=0xFFFFFFFF -> 0 at cycle 1; DIV same operands -> 0x80000000.
- Back-pressure: out_ready=0 for 5 cycles after out_valid -> out_result stable, in_ready=0 throughout. After the handshake, in_ready=1 on the next cycle.
- Flush at BUSY cycle 10 of DIV -> IDLE next cycle, no out_valid. A new MUL 3x5 issued immediately -> 15 after 33 cycles. Flush together with in_valid in IDLE -> no accept.
- rst asserted mid-BUSY (async, between edges) -> outputs at reset values immediately. Then a random 2000-op compare against a reference model for all 8 ops, including corner operands 0, 1, -1, 0x80000000, 0x7FFFFFFF.
